// File: rtl/comp_dcd.sv
// Comparator-flag condition decoder.
// Selects one of six relational conditions from the greater/equal flags,
// presents it combinationally on z[0], and keeps an enabled registered copy.
module comp_dcd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        grtr_in,
    input  logic        eql_in,
    input  logic [2:0]  ctrl,
    input  logic        en,
    output logic [31:0] z,
    output logic [31:0] z_q,
    output logic        ctrl_err,
    output logic        ctrl_err_q
);

    logic cond;
    logic ctrl_bad;

    // Codes 110 and 111 are unused; plain gates let X/Z on ctrl propagate.
    assign ctrl_bad = ctrl[2] & ctrl[1];

    // Condition select as a mux tree so unknown inputs are not resolved.
    assign cond = ctrl_bad ? 1'b0 :
                  ctrl[2]  ? (ctrl[0] ? ~eql_in : eql_in) :
                  ctrl[1]  ? (ctrl[0] ? (grtr_in | eql_in) : (grtr_in & ~eql_in)) :
                             (ctrl[0] ? (~grtr_in | eql_in) : (~grtr_in & ~eql_in));

    assign z        = {31'd0, cond};
    assign ctrl_err = ctrl_bad;

    // Registered copy: async clear, load on enable, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q        <= '0;
            ctrl_err_q <= 1'b0;
        end else if (en) begin
            z_q        <= z;
            ctrl_err_q <= ctrl_err;
        end
    end

endmodule

// File: tb/tb_comp_dcd.sv
// Self-checking bench for comp_dcd: directed sweeps, exhaustive decode,
// randomized register traffic against a behavioural model, reset cases.
module tb_comp_dcd;

    logic        clk;
    logic        rst_n;
    logic        grtr_in;
    logic        eql_in;
    logic [2:0]  ctrl;
    logic        en;
    logic [31:0] z;
    logic [31:0] z_q;
    logic        ctrl_err;
    logic        ctrl_err_q;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [31:0] exp_zq;
    logic        exp_errq;

    comp_dcd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .grtr_in    (grtr_in),
        .eql_in     (eql_in),
        .ctrl       (ctrl),
        .en         (en),
        .z          (z),
        .z_q        (z_q),
        .ctrl_err   (ctrl_err),
        .ctrl_err_q (ctrl_err_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decode the relation between A and B from the flags, then
    // answer the selected question about that relation.
    function automatic logic [31:0] ref_z(input logic [2:0] c, input logic g, input logic e);
        bit r;
        case (c)
            3'd0: r = !g && !e;
            3'd1: r = !g || e;
            3'd2: r = g && !e;
            3'd3: r = g || e;
            3'd4: r = e;
            3'd5: r = !e;
            default: r = 0;
        endcase
        return {31'd0, r};
    endfunction

    function automatic logic ref_err(input logic [2:0] c);
        return (c >= 3'd6);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag);
        chk({tag, " z"}, z, ref_z(ctrl, grtr_in, eql_in));
        chk({tag, " ctrl_err"}, {31'd0, ctrl_err}, {31'd0, ref_err(ctrl)});
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, " z_q"}, z_q, exp_zq);
        chk({tag, " ctrl_err_q"}, {31'd0, ctrl_err_q}, {31'd0, exp_errq});
    endtask

    logic [2:0] t_ctrl [6];
    logic       t_g    [6];
    logic       t_e    [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        grtr_in  = 1'b0;
        eql_in   = 1'b0;
        ctrl     = 3'd0;
        en       = 1'b0;
        exp_zq   = '0;
        exp_errq = 1'b0;

        #1;
        chk_regs("reset state");
        chk_comb("during reset");

        // Release between edges, keep en low while sweeping.
        #11 rst_n = 1'b1;

        // True sweep.
        t_ctrl = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        t_g    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        t_e    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            ctrl = t_ctrl[i]; grtr_in = t_g[i]; eql_in = t_e[i];
            #1;
            chk($sformatf("true sweep %0d", i), z, 32'd1);
            #9;
        end

        // False sweep.
        t_g = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        t_e = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            ctrl = t_ctrl[i]; grtr_in = t_g[i]; eql_in = t_e[i];
            #1;
            chk($sformatf("false sweep %0d", i), z, 32'd0);
            #9;
        end

        // Exhaustive decode; registers must hold since en is low.
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = i[4:0];
            ctrl = v[4:2]; grtr_in = v[1]; eql_in = v[0];
            #1;
            chk_comb($sformatf("exhaustive %0d", i));
            #4;
        end
        chk_regs("hold with en=0");

        // Randomized traffic with enable toggling.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ctrl    = 3'($urandom_range(0, 7));
            grtr_in = 1'($urandom);
            eql_in  = 1'($urandom);
            en      = 1'($urandom);
            #1;
            if (i % 8 == 0) chk_comb($sformatf("rand comb %0d", i));
            if (en) begin
                exp_zq   = ref_z(ctrl, grtr_in, eql_in);
                exp_errq = ref_err(ctrl);
            end
            @(posedge clk);
            #1;
            chk_regs($sformatf("rand reg %0d", i));
        end

        // Illegal code capture.
        @(negedge clk);
        ctrl = 3'b111; grtr_in = 1'b1; eql_in = 1'b1; en = 1'b1;
        #1;
        chk("illegal z", z, 32'd0);
        chk("illegal ctrl_err", {31'd0, ctrl_err}, 32'd1);
        @(posedge clk);
        #1;
        exp_zq = 32'd0; exp_errq = 1'b1;
        chk_regs("illegal captured");

        // Register timing.
        @(negedge clk);
        ctrl = 3'b010; grtr_in = 1'b1; eql_in = 1'b0; en = 1'b1;
        #1;
        chk("timing z now", z, 32'd1);
        chk("timing z_q before edge", z_q, 32'd0);
        @(posedge clk);
        #1;
        chk("timing z_q after edge", z_q, 32'd1);
        chk("timing ctrl_err_q after edge", {31'd0, ctrl_err_q}, 32'd0);
        @(negedge clk);
        en = 1'b0; eql_in = 1'b1;
        #1;
        chk("timing z after e=1", z, 32'd0);
        @(posedge clk);
        #1;
        chk("timing z_q held", z_q, 32'd1);

        // Mid-operation asynchronous reset.
        #2 rst_n = 1'b0;
        #1;
        chk("async reset z_q", z_q, 32'd0);
        chk("async reset ctrl_err_q", {31'd0, ctrl_err_q}, 32'd0);
        chk("async reset z unchanged", z, 32'd0);
        eql_in = 1'b0;
        #1;
        chk("z during reset", z, 32'd1);
        @(posedge clk);
        #1;
        chk("z_q held in reset", z_q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        #1;
        chk("z_q before first capture", z_q, 32'd0);
        @(posedge clk);
        #1;
        chk("first capture after reset", z_q, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/comp_dcd.md
COMP_DCD -- requirements
Module: comp_dcd

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all registered outputs.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 grtr_in  input  1  comparator flag: operand A greater than operand B.
REQ-005 eql_in  input  1  comparator flag: operand A equal to operand B.
REQ-006 ctrl  input  3  condition select code (see REQ-010).
REQ-007 en  input  1  capture enable for registered outputs.
REQ-008 z  output  32  combinational condition result, zero-extended to 32 bits.
REQ-009 z_q  output  32  registered copy of z; ctrl_err  output  1  combinational flag for an illegal ctrl code; ctrl_err_q  output  1  registered copy of ctrl_err.

Function
REQ-010 Condition codes, with g = grtr_in and e = eql_in:
- 000 LT: ~g & ~e
- 001 LE: ~g | e
- 010 GT: g & ~e
- 011 GE: g | e
- 100 EQ: e
- 101 NE: ~e
REQ-011 z[0] SHALL equal the selected condition; z[31:1] SHALL be 0 at all times.
REQ-012 z and ctrl_err SHALL be purely combinational, with zero-cycle latency from grtr_in, eql_in and ctrl, and independent of clk, rst_n and en.
REQ-013 ctrl codes 110 and 111 are illegal: z SHALL be 32'd0 and ctrl_err SHALL be 1; for codes 000-101, ctrl_err SHALL be 0.
REQ-014 The contradictory input pair g=1, e=1 SHALL NOT be special-cased; the REQ-010 equations apply unchanged (e.g., GE gives 1, GT gives 0, LE gives 1).
REQ-015 On each rising clk edge with rst_n=1 and en=1, z_q SHALL load z and ctrl_err_q SHALL load ctrl_err (latency 1 cycle).
REQ-016 On a rising clk edge with en=0, z_q and ctrl_err_q SHALL hold their values.
REQ-017 X or Z on any input SHALL NOT be resolved inside the block; no internal state exists other than z_q and ctrl_err_q.

Reset
REQ-018 While rst_n=0, z_q SHALL be 32'd0 and ctrl_err_q SHALL be 0, asserted immediately without waiting for a clock edge.
REQ-019 Reset release SHALL be synchronous to clk; the first capture occurs on the first rising edge with rst_n=1 and en=1.
REQ-020 Reset SHALL NOT affect z or ctrl_err.
REQ-021 Asserting reset mid-operation SHALL clear z_q and ctrl_err_q at once; a captured value is never retained across reset.

Verification
REQ-022 True sweep (each step applied 10 time units apart) -> z=1 every step:
- ctrl=000, g=0, e=0
- ctrl=001, g=0, e=1
- ctrl=010, g=1, e=0
- ctrl=011, g=1, e=1
- ctrl=100, g=0, e=1
- ctrl=101, g=1, e=0
REQ-023 False sweep -> z=0 every step:
- ctrl=000, g=0, e=1
- ctrl=001, g=1, e=0
- ctrl=010, g=0, e=1
- ctrl=011, g=0, e=0
- ctrl=100, g=0, e=0
- ctrl=101, g=0, e=1
REQ-024 Exhaustive check: all 32 combinations of ctrl, g and e -> z matches REQ-010/REQ-013, z[31:1]=0, ctrl_err=1 only for ctrl=110 and 111.
REQ-025 Illegal code: ctrl=111, g=1, e=1 -> z=0, ctrl_err=1; after one en=1 clock edge, z_q=0 and ctrl_err_q=1.
REQ-026 Register timing:
- With en=1, ctrl=010, g=1, e=0: z=1 immediately; z_q=0 before the edge and 1 after it.
- Then set en=0 and e=1: z=0 while z_q stays 1.
REQ-027 Reset: with z_q=1, drive rst_n=0 between clock edges -> z_q=0 immediately; z unchanged; after release with en=1, z_q follows z on the next edge.
